// File: rtl/galivan_ioctl_pkg.sv
// Shared types and constants for the hps_io ioctl upload responder.
package galivan_ioctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GNT,
    RD_LO,
    RD_HI,
    DONE
  } upload_state_t;

  localparam logic [7:0]  HISCORE_INDEX = 8'd4;
  localparam logic [15:0] OOR_WORD      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam int unsigned IOCTL_ADDR_W  = 27;
  localparam int unsigned LAT_CNT_W     = 3;

  // CRC-16/CCITT, MSB first, one byte folded into the running value.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/hiscore_upload_if.sv
// ioctl upload channel plus core-RAM arbitration/read port.
interface hiscore_upload_if #(
  parameter int unsigned ADDR_W = 10
) ();
  import galivan_ioctl_pkg::*;

  logic                    ioctl_upload;
  logic [7:0]              ioctl_index;
  logic                    ioctl_rd;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [15:0]             ioctl_din;
  logic                    ioctl_wait;
  logic                    mem_req;
  logic                    mem_gnt;
  logic                    mem_rd;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_dout;

  // Responder side (this block).
  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_gnt, mem_dout,
    output ioctl_din, ioctl_wait, mem_req, mem_rd, mem_addr
  );

  // hps_io / RAM arbiter side.
  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_gnt, mem_dout,
    input  ioctl_din, ioctl_wait, mem_req, mem_rd, mem_addr
  );

endinterface

// File: rtl/hiscore_upload.sv
// Upload responder: serves hps_io word reads from core NVRAM/hiscore RAM.
// Optional build macro HISCORE_UPLOAD_CRC_EN adds a running CRC-16 of the
// delivered bytes (crc / crc_valid ports).
module hiscore_upload
  import galivan_ioctl_pkg::*;
#(
  parameter logic [7:0]  INDEX      = HISCORE_INDEX,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned SIZE_BYTES = 1024,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  hiscore_upload_if.slave   bus,
  output logic              proto_err
`ifdef HISCORE_UPLOAD_CRC_EN
  ,
  output logic [15:0]       crc,
  output logic              crc_valid
`endif
);

  // mem_dout is sampled on the MEM_LAT-th clock edge after the edge that raised mem_rd.
  localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(MEM_LAT);

  upload_state_t          state_q, state_d;
  logic [ADDR_W-2:0]      addr_q, addr_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]             lo_q, lo_d, hi_q, hi_d;
  logic [15:0]            din_q, din_d;
  logic                   wait_q, wait_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   proto_err_q, proto_err_d;

  logic                    session_c;
  logic [IOCTL_ADDR_W-1:0] word_addr_c;
  logic                    oor_c;

  // Session qualification and word-aligned range check.
  always_comb begin
    session_c   = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    word_addr_c = bus.ioctl_addr & ~IOCTL_ADDR_W'(1);
    oor_c       = word_addr_c >= IOCTL_ADDR_W'(SIZE_BYTES);
  end

  // Next-state and output logic for the word fetch sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    din_d       = din_q;
    wait_d      = wait_q;
    mem_req_d   = session_c;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    proto_err_d = proto_err_q | (session_c && bus.ioctl_rd && (state_q != IDLE));

    if ((state_q != IDLE) && !session_c) begin
      // Session vanished mid-fetch: drop the word, keep the last delivered one.
      state_d = IDLE;
      wait_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (session_c && bus.ioctl_rd) begin
            addr_d = word_addr_c[ADDR_W-1:1];
            wait_d = 1'b1;
            if (oor_c) begin
              lo_d    = OOR_WORD[7:0];
              hi_d    = OOR_WORD[15:8];
              state_d = DONE;
            end else begin
              state_d = GNT;
            end
          end
        end
        GNT: begin
          if (bus.mem_gnt) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {addr_q, 1'b0};
            cnt_d      = LAT;
            state_d    = RD_LO;
          end
        end
        RD_LO: begin
          // cnt==1: low byte lands this edge; cnt==0: byte held, waiting for grant.
          if (cnt_q != '0) cnt_d = cnt_q - LAT_CNT_W'(1);
          if (cnt_q == LAT_CNT_W'(1)) lo_d = bus.mem_dout;
          if ((cnt_q <= LAT_CNT_W'(1)) && bus.mem_gnt) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {addr_q, 1'b1};
            cnt_d      = LAT;
            state_d    = RD_HI;
          end
        end
        RD_HI: begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
          if (cnt_q == LAT_CNT_W'(1)) begin
            hi_d    = bus.mem_dout;
            state_d = DONE;
          end
        end
        DONE: begin
          din_d   = {hi_q, lo_q};
          wait_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      din_q       <= '0;
      wait_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign proto_err      = proto_err_q;

`ifdef HISCORE_UPLOAD_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_valid_q, crc_valid_d;

  // Running CRC: restart on session entry, fold lo then hi of each delivered word.
  always_comb begin
    crc_d       = crc_q;
    crc_valid_d = mem_req_q && !session_c;
    if (session_c && !mem_req_q) begin
      crc_d = CRC16_INIT;
    end else if ((state_q == DONE) && session_c) begin
      crc_d = crc16_byte(crc16_byte(crc_q, lo_q), hi_q);
    end
  end

  // CRC registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign crc       = crc_q;
  assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload (optional CRC test with HISCORE_UPLOAD_CRC_EN).
module tb_hiscore_upload;
  import galivan_ioctl_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic proto_err;
`ifdef HISCORE_UPLOAD_CRC_EN
  logic [15:0] crc;
  logic        crc_valid;
`endif

  int total = 0;
  int bad   = 0;
  int rd_count = 0;
  int rd_nogrant = 0;

  logic [7:0] ram [0:1023];

  always #5 clk_sys = ~clk_sys;

  hiscore_upload_if #(.ADDR_W(10)) bus ();

  hiscore_upload #(
    .INDEX(8'd4), .ADDR_W(10), .SIZE_BYTES(1024), .MEM_LAT(2)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (bus),
    .proto_err (proto_err)
`ifdef HISCORE_UPLOAD_CRC_EN
    ,
    .crc       (crc),
    .crc_valid (crc_valid)
`endif
  );

  // Synchronous RAM: data registered one cycle after mem_rd.
  always @(posedge clk_sys) begin
    if (bus.mem_rd === 1'b1) begin
      bus.mem_dout <= ram[bus.mem_addr];
      rd_count <= rd_count + 1;
      if (bus.mem_gnt !== 1'b1) rd_nogrant <= rd_nogrant + 1;
    end
  end

  // Issue one word read at a negedge; lat = first cycle wait is seen low (-1 on timeout).
  task automatic do_read(input logic [26:0] a, input int maxc, output int lat);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    lat = 1;
    while (bus.ioctl_wait !== 1'b0 && lat < maxc) begin
      @(negedge clk_sys);
      lat++;
    end
    if (bus.ioctl_wait !== 1'b0) lat = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index  = 8'd4;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.mem_gnt      = 1'b1;
    bus.mem_dout     = 8'h00;
    repeat (3) @(negedge clk_sys);
    total++;
    if ({bus.ioctl_din, bus.ioctl_wait, bus.mem_req, bus.mem_rd, bus.mem_addr, proto_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got din=%h wait=%b req=%b rd=%b addr=%h perr=%b want all zero",
               bus.ioctl_din, bus.ioctl_wait, bus.mem_req, bus.mem_rd, bus.mem_addr, proto_err);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL mem_req_session: got %b want 1", bus.mem_req);
    end
  endtask

  task automatic test_basic_read();
    int lat;
    int rd0;
    rd0 = rd_count;
    do_read(27'd0, 40, lat);
    total++;
    if (lat !== 7) begin bad++; $display("FAIL basic_latency: got %0d want 7", lat); end
    total++;
    if (bus.ioctl_din !== 16'h1234) begin bad++; $display("FAIL basic_din: got %h want 1234", bus.ioctl_din); end
    total++;
    if (rd_count - rd0 !== 2) begin bad++; $display("FAIL basic_rd_pulses: got %0d want 2", rd_count - rd0); end
  endtask

  task automatic test_out_of_range();
    int lat;
    int rd0;
    rd0 = rd_count;
    do_read(27'd1024, 20, lat);
    total++;
    if (lat < 2 || lat > 3) begin bad++; $display("FAIL oor_latency: got %0d want 2..3", lat); end
    total++;
    if (bus.ioctl_din !== 16'hFFFF) begin bad++; $display("FAIL oor_din: got %h want ffff", bus.ioctl_din); end
    total++;
    if (rd_count - rd0 !== 0) begin bad++; $display("FAIL oor_rd_pulses: got %0d want 0", rd_count - rd0); end
    // Last in-range word, addressed with bit0 set (bit0 is ignored).
    do_read(27'd1023, 40, lat);
    total++;
    if (lat !== 7 || bus.ioctl_din !== 16'hCDAB) begin
      bad++;
      $display("FAIL last_word: got lat=%0d din=%h want lat=7 din=cdab", lat, bus.ioctl_din);
    end
  endtask

  task automatic test_grant_stall();
    int lat;
    int rd0;
    int rd_early;
    rd0 = rd_count;
    bus.mem_gnt    = 1'b0;
    bus.ioctl_addr = 27'd2;
    bus.ioctl_rd   = 1'b1;
    lat = 0;
    rd_early = 0;
    while (lat < 60) begin
      @(negedge clk_sys);
      lat++;
      bus.ioctl_rd = 1'b0;
      if (lat == 21) begin
        rd_early = rd_count - rd0;
        bus.mem_gnt = 1'b1;
      end
      if (lat > 1 && bus.ioctl_wait === 1'b0) break;
    end
    total++;
    if (rd_early !== 0) begin bad++; $display("FAIL stall_no_rd: got %0d pulses want 0", rd_early); end
    total++;
    if (lat !== 27) begin bad++; $display("FAIL stall_latency: got %0d want 27", lat); end
    total++;
    if (bus.ioctl_din !== 16'h7856) begin bad++; $display("FAIL stall_din: got %h want 7856", bus.ioctl_din); end
  endtask

  task automatic test_session_abort();
    bus.ioctl_addr = 27'd4;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++;
    if (dut.state_q !== RD_HI) begin bad++; $display("FAIL abort_setup_state: got %0d want RD_HI", dut.state_q); end
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    total++;
    if (bus.ioctl_wait !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_rd !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs: got wait=%b req=%b rd=%b want 0 0 0", bus.ioctl_wait, bus.mem_req, bus.mem_rd);
    end
    total++;
    if (dut.state_q !== IDLE) begin bad++; $display("FAIL abort_state: got %0d want IDLE", dut.state_q); end
    total++;
    if (bus.ioctl_din !== 16'h7856) begin bad++; $display("FAIL abort_din: got %h want 7856", bus.ioctl_din); end
    bus.ioctl_upload = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_wrong_index();
    int rd0;
    int wait_seen;
    rd0 = rd_count;
    wait_seen = 0;
    bus.ioctl_index = 8'd5;
    @(negedge clk_sys);
    bus.ioctl_addr = 27'd0;
    bus.ioctl_rd   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0;
      if (bus.ioctl_wait !== 1'b0) wait_seen++;
    end
    total++;
    if (wait_seen !== 0 || bus.mem_req !== 1'b0 || rd_count - rd0 !== 0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL wrong_index: got wait_cycles=%0d req=%b rds=%0d perr=%b want 0 0 0 0",
               wait_seen, bus.mem_req, rd_count - rd0, proto_err);
    end
    bus.ioctl_index = 8'd4;
    @(negedge clk_sys);
  endtask

  task automatic test_proto_err();
    int lat;
    bus.ioctl_addr = 27'd6;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_err_set: got %b want 1", proto_err); end
    lat = 3;
    while (bus.ioctl_wait !== 1'b0 && lat < 40) begin
      @(negedge clk_sys);
      lat++;
    end
    total++;
    if (lat !== 7 || bus.ioctl_din !== 16'h2211) begin
      bad++;
      $display("FAIL proto_first_word: got lat=%0d din=%h want lat=7 din=2211", lat, bus.ioctl_din);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_read(27'd4, 40, lat);
    total++;
    if (lat !== 7 || bus.ioctl_din !== 16'hBC9A) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d din=%h want lat=7 din=bc9a", lat, bus.ioctl_din);
    end
    do_read(27'd8, 40, lat);
    total++;
    if (lat !== 7 || bus.ioctl_din !== 16'h4433) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d din=%h want lat=7 din=4433", lat, bus.ioctl_din);
    end
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_err_sticky: got %b want 1", proto_err); end
    total++;
    if (rd_nogrant !== 0) begin bad++; $display("FAIL rd_without_grant: got %0d want 0", rd_nogrant); end
  endtask

`ifdef HISCORE_UPLOAD_CRC_EN
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic test_crc();
    int lat;
    logic [15:0] exp_crc;
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b1;
    @(negedge clk_sys);
    total++;
    if (crc !== 16'hFFFF) begin bad++; $display("FAIL crc_init: got %h want ffff", crc); end
    exp_crc = 16'hFFFF;
    for (int a = 32; a < 42; a += 2) begin
      do_read(27'(a), 40, lat);
      exp_crc = ref_crc(ref_crc(exp_crc, ram[a]), ram[a+1]);
    end
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    total++;
    if (crc_valid !== 1'b1 || crc !== exp_crc) begin
      bad++;
      $display("FAIL crc_end: got valid=%b crc=%h want valid=1 crc=%h", crc_valid, crc, exp_crc);
    end
    @(negedge clk_sys);
    total++;
    if (crc_valid !== 1'b0) begin bad++; $display("FAIL crc_valid_pulse: got %b want 0", crc_valid); end
    bus.ioctl_upload = 1'b1;
    @(negedge clk_sys);
  endtask
`endif

  task automatic test_reset_midread();
    bus.ioctl_addr = 27'd0;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    total++;
    if (bus.ioctl_wait !== 1'b0 || bus.ioctl_din !== 16'h0000 || proto_err !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_midread: got wait=%b din=%h perr=%b req=%b want 0 0000 0 0",
               bus.ioctl_wait, bus.ioctl_din, proto_err, bus.mem_req);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[0] = 8'h34;   ram[1] = 8'h12;
    ram[2] = 8'h56;   ram[3] = 8'h78;
    ram[4] = 8'h9A;   ram[5] = 8'hBC;
    ram[6] = 8'h11;   ram[7] = 8'h22;
    ram[8] = 8'h33;   ram[9] = 8'h44;
    ram[1022] = 8'hAB; ram[1023] = 8'hCD;
    for (int i = 0; i < 9; i++) ram[32+i] = 8'h31 + 8'(i);
    ram[41] = 8'h0A;

    test_reset();
    test_basic_read();
    test_out_of_range();
    test_grant_stall();
    test_session_abort();
    test_wrong_index();
    test_proto_err();
    test_back_to_back();
`ifdef HISCORE_UPLOAD_CRC_EN
    test_crc();
`endif
    test_reset_midread();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
